// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of a 5-stage in-order pipeline. Owns the program
// counter and the IF/ID pipeline register.
//
//   * PC priority:    redirect > (stall_pc | !imem_ready) > PC+4
//   * IF/ID priority: redirect (bubble) > stall_if_id (hold)
//                     > !imem_ready (bubble) > capture
//
// Parameters
//   RESET_PC    fetch address loaded while rst is high
//   NOP_INSTR   encoding used for pipeline bubbles (addi x0,x0,0)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   stall_pc     hold the PC (load-use stall)
//   stall_if_id  hold the IF/ID register (load-use stall)
//   redirect     taken branch/jump resolved in EX: reload PC, flush IF/ID
//   redirect_pc  branch/jump target (low two bits ignored)
//   imem_addr    instruction memory address (the PC register itself)
//   imem_rdata   instruction word for imem_addr
//   imem_ready   imem_rdata is valid this cycle
//   if_id_pc     PC of the instruction held in IF/ID
//   if_id_instr  instruction held in IF/ID
//   if_id_valid  IF/ID holds a real instruction (0 = bubble)
//   if_id_rs1    source register field instr[19:15]
//   if_id_rs2    source register field instr[24:20]
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        stall_if_id,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [4:0]  if_id_rs1,
  output logic [4:0]  if_id_rs2
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;

  // PC next state. A redirect beats every hold condition so a taken branch
  // is never lost behind a memory wait or a load-use stall.
  always_comb begin
    // NOTE: every signal gets a default before the branches; a path that
    // leaves one unassigned would infer a latch.
    pc_d = pc_q;
    if (redirect) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (!stall_pc && imem_ready) begin
      pc_d = pc_q + 32'd4;  // wraps naturally modulo 2^32
    end
  end

  // IF/ID next state. On redirect the pc field is left alone: only the
  // instruction/valid pair matters for a bubble.
  always_comb begin
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    if (redirect) begin
      if_instr_d = NOP_INSTR;
      if_valid_d = 1'b0;
    end else if (stall_if_id) begin
      // hold everything
    end else if (!imem_ready) begin
      if_pc_d    = pc_q;
      if_instr_d = NOP_INSTR;
      if_valid_d = 1'b0;
    end else begin
      if_pc_d    = pc_q;
      if_instr_d = imem_rdata;
      if_valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      if_pc_q    <= 32'h0000_0000;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_pc    = if_pc_q;
  assign if_id_instr = if_instr_q;
  assign if_id_valid = if_valid_q;
  assign if_id_rs1   = if_instr_q[19:15];
  assign if_id_rs2   = if_instr_q[24:20];

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. Two instances share the control inputs:
// dut uses the default RESET_PC, dut_w uses 32'hFFFF_FFFC to exercise the
// address wrap. Each step the reference model predicts the IF/ID contents,
// pushes them to a scoreboard queue, and the entry is popped and compared
// one time unit after the clock edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_pc, stall_if_id, redirect, imem_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rdata, if_id_pc, if_id_instr;
  logic        if_id_valid;
  logic [4:0]  if_id_rs1, if_id_rs2;

  logic [31:0] imem_addr_w, imem_rdata_w, if_id_pc_w, if_id_instr_w;
  logic        if_id_valid_w;
  logic [4:0]  if_id_rs1_w, if_id_rs2_w;

  int errors = 0;
  int checks = 0;

  ifid_t       sb_q[$];
  ifid_t       m_ifid;
  logic [31:0] m_pc, m_pc_w;

  always #5 clk = ~clk;

  // Address-tagged memory contents; never equal to the NOP encoding in the
  // address ranges used here.
  function automatic logic [31:0] tag(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata   = tag(imem_addr);
  assign imem_rdata_w = tag(imem_addr_w);

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_pc(stall_pc), .stall_if_id(stall_if_id),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .stall_pc(stall_pc), .stall_if_id(stall_if_id),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem_addr(imem_addr_w),
    .imem_rdata(imem_rdata_w), .imem_ready(imem_ready), .if_id_pc(if_id_pc_w),
    .if_id_instr(if_id_instr_w), .if_id_valid(if_id_valid_w),
    .if_id_rs1(if_id_rs1_w), .if_id_rs2(if_id_rs2_w)
  );

  task automatic check(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Model of the PC update rule.
  function automatic logic [31:0] next_pc(input logic [31:0] pc,
      input logic sp, input logic rd, input logic [31:0] tgt, input logic rdy);
    if (rd) return {tgt[31:2], 2'b00};
    if (sp || !rdy) return pc;
    return pc + 32'd4;
  endfunction

  // Drive one cycle of stimulus (called one time unit after a rising edge),
  // predict IF/ID, wait for the edge, then pop and compare.
  task automatic step(input string name, input logic sp, input logic si,
                      input logic rd, input logic [31:0] tgt, input logic rdy);
    ifid_t e;
    ifid_t got;
    stall_pc = sp; stall_if_id = si; redirect = rd; redirect_pc = tgt;
    imem_ready = rdy;
    e = m_ifid;
    if (rd) begin
      e.instr = NOP; e.valid = 1'b0;
    end else if (si) begin
      // hold
    end else if (!rdy) begin
      e.pc = m_pc; e.instr = NOP; e.valid = 1'b0;
    end else begin
      e.pc = m_pc; e.instr = tag(m_pc); e.valid = 1'b1;
    end
    sb_q.push_back(e);
    m_ifid = e;
    m_pc   = next_pc(m_pc, sp, rd, tgt, rdy);
    m_pc_w = next_pc(m_pc_w, sp, rd, tgt, rdy);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check({name, ".pc"},    if_id_pc, got.pc);
    check({name, ".instr"}, if_id_instr, got.instr);
    check({name, ".valid"}, {31'b0, if_id_valid}, {31'b0, got.valid});
    check({name, ".rs"}, {22'b0, if_id_rs2, if_id_rs1},
          {22'b0, got.instr[24:20], got.instr[19:15]});
    check({name, ".addr"},   imem_addr, m_pc);
    check({name, ".addr_w"}, imem_addr_w, m_pc_w);
  endtask

  initial begin
    rst = 1'b1; stall_pc = 1'b0; stall_if_id = 1'b0; redirect = 1'b0;
    redirect_pc = '0; imem_ready = 1'b0;
    m_pc = 32'h0; m_pc_w = 32'hFFFF_FFFC;
    m_ifid.pc = 32'h0; m_ifid.instr = NOP; m_ifid.valid = 1'b0;

    // Reset values, before any clock edge.
    #2;
    check("rst.addr",   imem_addr, 32'h0);
    check("rst.addr_w", imem_addr_w, 32'hFFFF_FFFC);
    check("rst.pc",     if_id_pc, 32'h0);
    check("rst.instr",  if_id_instr, NOP);
    check("rst.valid",  {31'b0, if_id_valid}, 32'h0);
    imem_ready = 1'b1;
    @(posedge clk); #1;
    check("rst.hold_addr", imem_addr, 32'h0);
    rst = 1'b0;

    // Sequential fetch 0,4,8,C; wrap instance goes FFFFFFFC -> 0.
    step("seq0", 0, 0, 0, 32'h0, 1);
    check("wrap.ifpc", if_id_pc_w, 32'hFFFF_FFFC);
    check("wrap.instr", if_id_instr_w, tag(32'hFFFF_FFFC));
    step("seq1", 0, 0, 0, 32'h0, 1);
    step("seq2", 0, 0, 0, 32'h0, 1);
    step("seq3", 0, 0, 0, 32'h0, 1);
    check("seq.at10", imem_addr, 32'h10);

    // Load-use stall for two cycles at PC=0x10; IF/ID keeps the 0x0C word.
    step("stall0", 1, 1, 0, 32'h0, 1);
    step("stall1", 1, 1, 0, 32'h0, 1);
    check("stall.held", if_id_pc, 32'h0C);
    for (int i = 0; i < 4; i++) step("resume", 0, 0, 0, 32'h0, 1);
    check("resume.at20", imem_addr, 32'h20);

    // Redirect to a misaligned target.
    step("redir", 0, 0, 1, 32'h103, 1);
    check("redir.addr", imem_addr, 32'h100);
    step("redir.cap", 0, 0, 0, 32'h0, 1);
    check("redir.cappc", if_id_pc, 32'h100);

    // Redirect together with stalls and a memory wait: redirect wins.
    step("redir_vs_all", 1, 1, 1, 32'h40, 0);
    check("rva.addr", imem_addr, 32'h40);

    // Three memory-wait cycles at 0x40, then a single capture.
    for (int i = 0; i < 3; i++) step("wait", 0, 0, 0, 32'h0, 0);
    step("wait.cap", 0, 0, 0, 32'h0, 1);
    check("wait.cappc", if_id_pc, 32'h40);

    // stall_pc alone: PC holds while IF/ID keeps capturing.
    step("spc_only", 1, 0, 0, 32'h0, 1);
    step("sid_only", 0, 1, 0, 32'h0, 1);

    // Mixed pseudo-random traffic against the model.
    for (int i = 0; i < 40; i++)
      step("rand", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 7) == 0), 32'($urandom_range(0, 255)) << 4 | 32'h3,
           1'($urandom_range(0, 3) != 0));

    // Asynchronous reset mid-stream while stalled and redirecting.
    stall_pc = 1'b1; stall_if_id = 1'b1; redirect = 1'b1;
    redirect_pc = 32'h500; imem_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("arst.addr",   imem_addr, 32'h0);
    check("arst.addr_w", imem_addr_w, 32'hFFFF_FFFC);
    check("arst.pc",     if_id_pc, 32'h0);
    check("arst.instr",  if_id_instr, NOP);
    check("arst.valid",  {31'b0, if_id_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
